// File: rtl/aes_pkg.sv
// Shared AES types, constants, the Rcon doubling helper and the forward S-box
// table used by the key-expansion engine.
package aes_pkg;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] block_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } state_e;

  localparam int AES_ROUNDS = 10;
  localparam int NUM_RKEYS  = 11;

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box: one byte in, one byte out, via the
// constant table in aes_pkg.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] sub_i,
  output logic [7:0] sub_o
);

  always_comb begin
    sub_o = SBOX[sub_i];
  end

endmodule

// File: rtl/aes_key_sched.sv
// Iterative AES-128 key expansion, one round key per clock, with an indexed
// combinational read port. Define AES_KEY_ZEROIZE_EN to add the zeroize port.
module aes_key_sched
  import aes_pkg::*;
#(
  parameter bit RD_ZERO_INVALID = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
`ifdef AES_KEY_ZEROIZE_EN
  input  logic         zeroize,
`endif
  input  logic [127:0] key_in,
  input  logic         key_load,
  output logic         busy,
  output logic         key_ready,
  input  logic [3:0]   rd_round,
  output logic [127:0] rd_key,
  output logic         rd_valid
);

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [7:0]             rcon_q, rcon_d;
  logic [NUM_RKEYS-1:0]   valid_q, valid_d;
  block_t                 last_q, last_d;
  block_t                 entry_q [NUM_RKEYS];
  block_t                 entry_d [NUM_RKEYS];

  word_t  w0, w1, w2, w3;
  word_t  rot_w, sub_w, t_w;
  word_t  n0, n1, n2, n3;
  block_t next_key;
  block_t rd_raw;
  logic   rd_hit;

  // last_q mirrors the most recently written entry, so the round function
  // never needs a wide read mux on the register file.
  assign w0    = last_q[127:96];
  assign w1    = last_q[95:64];
  assign w2    = last_q[63:32];
  assign w3    = last_q[31:0];
  assign rot_w = {w3[23:0], w3[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_subword
    aes_sbox u_sbox (
      .sub_i(rot_w[8*i +: 8]),
      .sub_o(sub_w[8*i +: 8])
    );
  end

  always_comb begin
    t_w      = sub_w ^ {rcon_q, 24'h000000};
    n0       = w0 ^ t_w;
    n1       = w1 ^ n0;
    n2       = w2 ^ n1;
    n3       = w3 ^ n2;
    next_key = {n0, n1, n2, n3};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rcon_d  = rcon_q;
    valid_d = valid_q;
    last_d  = last_q;
    entry_d = entry_q;
`ifdef AES_KEY_ZEROIZE_EN
    if (zeroize) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
      rcon_d  = 8'h01;
      valid_d = '0;
      last_d  = '0;
      entry_d = '{default: '0};
    end else
`endif
    if (key_load) begin
      // A load in any state restarts from round 0 and drops older valid bits.
      state_d    = EXPAND;
      cnt_d      = 4'd1;
      rcon_d     = 8'h01;
      valid_d    = NUM_RKEYS'(1);
      last_d     = key_in;
      entry_d[0] = key_in;
    end else if (state_q == EXPAND) begin
      for (int i = 1; i < NUM_RKEYS; i++) begin
        if (cnt_q == 4'(i)) begin
          entry_d[i] = next_key;
        end
      end
      last_d  = next_key;
      valid_d = valid_q | (NUM_RKEYS'(1) << cnt_q);
      cnt_d   = cnt_q + 4'd1;
      rcon_d  = xtime(rcon_q);
      if (cnt_q == 4'(AES_ROUNDS)) begin
        state_d = READY;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rcon_q  <= 8'h01;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rcon_q  <= rcon_d;
      valid_q <= valid_d;
    end
  end

  // Key storage is left un-reset unless zeroization is built in.
`ifdef AES_KEY_ZEROIZE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q  <= '0;
      entry_q <= '{default: '0};
    end else begin
      last_q  <= last_d;
      entry_q <= entry_d;
    end
  end
`else
  always_ff @(posedge clk) begin
    last_q  <= last_d;
    entry_q <= entry_d;
  end
`endif

  assign busy      = (state_q == EXPAND);
  assign key_ready = (state_q == READY);

  // Indices 11..15 match no entry, so they read as invalid and zero.
  always_comb begin
    rd_raw = '0;
    rd_hit = 1'b0;
    for (int i = 0; i < NUM_RKEYS; i++) begin
      if (rd_round == 4'(i)) begin
        rd_raw = entry_q[i];
        rd_hit = valid_q[i];
      end
    end
    rd_valid = rd_hit;
    rd_key   = (RD_ZERO_INVALID && !rd_hit) ? '0 : rd_raw;
  end

endmodule

// File: tb/tb_aes_key_sched.sv
// Self-checking bench for aes_key_sched: FIPS-197 vectors, restart, async
// reset and randomized traffic against a word-level key-expansion model.
`timescale 1ns/1ps
module tb_aes_key_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] key_in;
  logic         key_load;
  logic         busy;
  logic         key_ready;
  logic [3:0]   rd_round;
  logic [127:0] rd_key;
  logic         rd_valid;
`ifdef AES_KEY_ZEROIZE_EN
  logic         zeroize;
`endif

  always #5 clk = ~clk;

  aes_key_sched #(.RD_ZERO_INVALID(1'b1)) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef AES_KEY_ZEROIZE_EN
    .zeroize  (zeroize),
`endif
    .key_in   (key_in),
    .key_load (key_load),
    .busy     (busy),
    .key_ready(key_ready),
    .rd_round (rd_round),
    .rd_key   (rd_key),
    .rd_valid (rd_valid)
  );

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  int           testsRun    = 0;
  int           testsFailed = 0;
  logic [7:0]   sbRef [256];
  logic [127:0] modelKeys [11];
  int           modelCount;

  // Compares one observed value with its expected value and logs mismatches.
  task automatic checkOutput(input string tag, input logic [127:0] actual,
                             input logic [127:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Field multiply in GF(2^8), shift-and-add form.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box derived from its definition: multiplicative inverse then affine map.
  task automatic buildSbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
          {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbRef[x] = s;
    end
  endtask

  // Textbook 44-word expansion producing all 11 round keys.
  task automatic expandModel(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] temp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      temp = w[i-1];
      if (i % 4 == 0) begin
        temp = {temp[23:0], temp[31:24]};
        temp = {sbRef[temp[31:24]], sbRef[temp[23:16]], sbRef[temp[15:8]], sbRef[temp[7:0]]};
        temp = temp ^ {rc, 24'h000000};
        rc   = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ temp;
    end
    for (int r = 0; r < 11; r++) modelKeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Drives one clock with an optional load and advances the model.
  task automatic applyStimulus(input logic ld, input logic [127:0] key);
    key_load = ld;
    key_in   = key;
    @(posedge clk);
    #1;
    key_load = 1'b0;
    if (ld) begin
      expandModel(key);
      modelCount = 1;
    end else if (modelCount >= 1 && modelCount < 11) begin
      modelCount++;
    end
  endtask

  task automatic checkStatus(input string tag);
    checkOutput({tag, ".busy"},  busy,      (modelCount >= 1 && modelCount <= 10));
    checkOutput({tag, ".ready"}, key_ready, (modelCount == 11));
  endtask

  task automatic checkRead(input int rd, input string tag);
    logic         expV;
    logic [127:0] expK;
    rd_round = 4'(rd);
    #0.2;
    expV = (rd <= 10) && (rd < modelCount);
    expK = '0;
    if (expV) expK = modelKeys[rd];
    checkOutput($sformatf("%s.valid[%0d]", tag, rd), rd_valid, expV);
    checkOutput($sformatf("%s.key[%0d]", tag, rd),   rd_key,   expK);
  endtask

  task automatic checkConst(input int rd, input logic [127:0] expK, input string tag);
    rd_round = 4'(rd);
    #0.2;
    checkOutput(tag, rd_key, expK);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int busyCount;
    int cyc;
    buildSbox();
    rst        = 1'b1;
    key_load   = 1'b0;
    key_in     = '0;
    rd_round   = 4'd0;
    modelCount = 0;
`ifdef AES_KEY_ZEROIZE_EN
    zeroize    = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    checkStatus("reset");
    checkRead(0, "reset");
    rst = 1'b0;

    // FIPS-197 key with progressive one-behind reads
    applyStimulus(1'b1, FIPS_KEY);
    busyCount = busy ? 1 : 0;
    checkStatus("fips.e0");
    checkRead(0, "fips.e0");
    checkRead(1, "fips.e0");
    cyc = 0;
    while (!key_ready && cyc < 20) begin
      applyStimulus(1'b0, '0);
      cyc++;
      if (busy) busyCount++;
      checkStatus("fips.prog");
      if (modelCount <= 10) begin
        checkRead(modelCount - 1, "fips.prog");
        checkRead(modelCount, "fips.prog");
      end
    end
    checkOutput("fips.busyCycles", busyCount, 10);
    checkOutput("fips.ready", key_ready, 1'b1);
    checkConst(1,  128'ha0fafe1788542cb123a339392a6c7605, "fips.rk1");
    checkConst(2,  128'hf2c295f27a96b9435935807a7359f67f, "fips.rk2");
    checkConst(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "fips.rk10");
    for (int r = 0; r < 16; r++) checkRead(r, "fips.ready");

    // Restart with an all-zero key during the 5th expansion cycle
    applyStimulus(1'b1, FIPS_KEY);
    repeat (4) applyStimulus(1'b0, '0);
    applyStimulus(1'b1, '0);
    for (int r = 0; r < 11; r++) checkRead(r, "restart.collapse");
    cyc = 0;
    while (!key_ready && cyc < 20) begin
      applyStimulus(1'b0, '0);
      cyc++;
    end
    checkOutput("restart.latency", cyc, 10);
    checkConst(10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e, "restart.rk10");

    // Asynchronous reset during the 3rd expansion cycle
    applyStimulus(1'b1, {$urandom, $urandom, $urandom, $urandom});
    repeat (2) applyStimulus(1'b0, '0);
    #2;
    rst = 1'b1;
    #0.5;
    modelCount = 0;
    checkStatus("asyncRst");
    for (int r = 0; r < 16; r++) checkRead(r, "asyncRst");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Randomized loads and reads against the model
    for (int n = 0; n < 400; n++) begin
      applyStimulus(($urandom_range(0, 13) == 0), {$urandom, $urandom, $urandom, $urandom});
      checkStatus("rand");
      checkRead($urandom_range(0, 15), "rand");
      if (modelCount >= 1 && modelCount <= 10) checkRead(modelCount - 1, "rand.track");
      if (modelCount == 11) checkRead($urandom_range(11, 15), "rand.oor");
    end

`ifdef AES_KEY_ZEROIZE_EN
    // Zeroize beats a simultaneous load
    applyStimulus(1'b1, {$urandom, $urandom, $urandom, $urandom});
    repeat (10) applyStimulus(1'b0, '0);
    checkStatus("zeroize.pre");
    zeroize  = 1'b1;
    key_load = 1'b1;
    key_in   = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk);
    #1;
    zeroize    = 1'b0;
    key_load   = 1'b0;
    modelCount = 0;
    checkStatus("zeroize");
    for (int r = 0; r < 16; r++) checkRead(r, "zeroize");
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
